cla_pipe_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor that succeeds the fixed 16-bit CLA. Operand width and pipeline depth are parameters. The datapath is built from 4-bit lookahead groups, and the word is split into equal slices, one per register stage, with the carry rippling between stages. It adds subtract mode, signed-overflow and zero flags, and a valid/ready handshake so it can sit directly in the execute stage of the team's datapath.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/cla_slice.sv | 67 ++++++
 rtl/cla_pipe_addsub.sv | 173 +++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// lookahead group width, group propagate/generate helper and result flag record.
package alu_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } result_flags_t;

    // Returns {P, G} for one 4-bit lookahead group.
    function automatic logic [1:0] group_pg(
        input logic [GROUP_W-1:0] p,
        input logic [GROUP_W-1:0] g
    );
        logic grp_p;
        logic grp_g;
        grp_p = &p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {grp_p, grp_g};
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead slice: 4-bit groups joined by a second-level
// lookahead that turns group P/G plus the slice carry-in into group carries.
module cla_slice
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    localparam int NG = W / GROUP_W;

    logic [W-1:0]  p;
    logic [W-1:0]  g;
    logic [W-1:0]  c_bit;
    logic [NG-1:0] grp_p;
    logic [NG-1:0] grp_g;
    logic [NG:0]   grp_c;
    logic          prod;
    logic          acc_c;

    always_comb begin
        p     = a ^ b;
        g     = a & b;
        grp_p = '0;
        grp_g = '0;
        for (int j = 0; j < NG; j++) begin
            {grp_p[j], grp_g[j]} = group_pg(p[j*GROUP_W +: GROUP_W], g[j*GROUP_W +: GROUP_W]);
        end
    end

    // Each group carry is a flat sum of products over the lower groups.
    always_comb begin
        grp_c = '0;
        prod  = 1'b1;
        acc_c = 1'b0;
        for (int j = 0; j <= NG; j++) begin
            prod  = 1'b1;
            acc_c = 1'b0;
            for (int i = j - 1; i >= 0; i--) begin
                acc_c = acc_c | (grp_g[i] & prod);
                prod  = prod & grp_p[i];
            end
            grp_c[j] = acc_c | (cin & prod);
        end
    end

    always_comb begin
        c_bit = '0;
        for (int j = 0; j < NG; j++) begin
            c_bit[j*GROUP_W] = grp_c[j];
            for (int t = 0; t < GROUP_W - 1; t++) begin
                c_bit[j*GROUP_W+t+1] = g[j*GROUP_W+t] | (p[j*GROUP_W+t] & c_bit[j*GROUP_W+t]);
            end
        end
    end

    assign sum   = p ^ c_bit;
    assign cout  = grp_c[NG];
    assign c_msb = c_bit[W-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one word slice per register stage,
// slice carries registered between stages, valid/ready handshake per stage.
module cla_pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   ready;

    // Subtract is folded in at the input, so later slices never need the mode bit.
    assign b_eff = b ^ {WIDTH{sub}};
    assign c0    = cin ^ sub;

    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = !valid_q[k] || ready[k+1];
        end
        up_valid    = '0;
        up_valid[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            up_valid[k] = valid_q[k-1];
        end
        load    = ready[STAGES-1:0] & up_valid;
        valid_d = valid_q;
        for (int k = 0; k < STAGES; k++) begin
            if (ready[k]) begin
                valid_d[k] = up_valid[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE_W = (k + 1) * SW;

        logic [SW-1:0]     sl_a;
        logic [SW-1:0]     sl_b;
        logic [SW-1:0]     sl_sum;
        logic              sl_cin;
        logic              sl_cout;
        logic              sl_cmsb;
        logic [DONE_W-1:0] psum_d;
        logic [DONE_W-1:0] psum_q;

        // Earlier result bits ride along under the new slice to keep the word aligned.
        if (k == 0) begin : g_src
            assign sl_a   = a[SW-1:0];
            assign sl_b   = b_eff[SW-1:0];
            assign sl_cin = c0;
            assign psum_d = sl_sum;
        end else begin : g_src
            assign sl_a   = g_stage[k-1].g_fwd.rema_q[SW-1:0];
            assign sl_b   = g_stage[k-1].g_fwd.remb_q[SW-1:0];
            assign sl_cin = g_stage[k-1].g_fwd.carry_q;
            assign psum_d = {sl_sum, g_stage[k-1].psum_q};
        end

        cla_slice #(
            .W(SW)
        ) u_slice (
            .a    (sl_a),
            .b    (sl_b),
            .cin  (sl_cin),
            .sum  (sl_sum),
            .cout (sl_cout),
            .c_msb(sl_cmsb)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                psum_q <= '0;
            end else if (load[k]) begin
                psum_q <= psum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int REM_W = WIDTH - DONE_W;

            logic [REM_W-1:0] rema_d;
            logic [REM_W-1:0] rema_q;
            logic [REM_W-1:0] remb_d;
            logic [REM_W-1:0] remb_q;
            logic             carry_d;
            logic             carry_q;
            logic             unused_c_msb;

            assign unused_c_msb = sl_cmsb;

            if (k == 0) begin : g_rem_src
                assign rema_d = a[WIDTH-1:SW];
                assign remb_d = b_eff[WIDTH-1:SW];
            end else begin : g_rem_src
                assign rema_d = g_stage[k-1].g_fwd.rema_q[REM_W+SW-1:SW];
                assign remb_d = g_stage[k-1].g_fwd.remb_q[REM_W+SW-1:SW];
            end

            assign carry_d = sl_cout;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rema_q  <= '0;
                    remb_q  <= '0;
                    carry_q <= 1'b0;
                end else if (load[k]) begin
                    rema_q  <= rema_d;
                    remb_q  <= remb_d;
                    carry_q <= carry_d;
                end
            end
        end else begin : g_out
            result_flags_t flags_d;
            result_flags_t flags_q;

            always_comb begin
                flags_d.cout = sl_cout;
                flags_d.ovf  = sl_cmsb ^ sl_cout;
                flags_d.zero = (psum_d == '0);
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    flags_q <= '0;
                end else if (load[k]) begin
                    flags_q <= flags_d;
                end
            end

            assign sum  = psum_q;
            assign cout = flags_q.cout;
            assign ovf  = flags_q.ovf;
            assign zero = flags_q.zero;
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed vector table on 1/2/4-stage builds, plus a
// randomized stream scored against an integer-arithmetic model of the 2-stage build.
module tb_cla_pipe_addsub;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
        logic        exp_zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        cin_in = 1'b0;
    logic        sub_in = 1'b0;

    logic        in_ready, out_valid, cout, ovf, zero;
    logic [31:0] sum;
    logic        in_ready_s1, out_valid_s1, cout_s1, ovf_s1, zero_s1;
    logic [31:0] sum_s1;
    logic        in_ready_s4, out_valid_s4, cout_s4, ovf_s4, zero_s4;
    logic [31:0] sum_s4;

    int          n_vectors = 0;
    int          n_miscompares = 0;
    logic [34:0] exp_q[$];
    bit          accepted_last = 1'b0;
    vec_t        vecs[7];

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_pipe_addsub #(.WIDTH(32), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s1),
        .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(out_valid_s1), .out_ready(out_ready),
        .sum(sum_s1), .cout(cout_s1), .ovf(ovf_s1), .zero(zero_s1)
    );

    cla_pipe_addsub #(.WIDTH(32), .STAGES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s4),
        .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(out_valid_s4), .out_ready(out_ready),
        .sum(sum_s4), .cout(cout_s4), .ovf(ovf_s4), .zero(zero_s4)
    );

    // Result packed as {cout, ovf, zero, sum}, computed with plain integer arithmetic.
    function automatic logic [34:0] ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                              input logic rc, input logic rs);
        longint ua, ub, sa, sb, uc, ur, sr;
        logic   co, ov;
        logic [31:0] s;
        ua = longint'(ra);
        ub = longint'(rb);
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        uc = longint'(rc);
        if (!rs) begin
            ur = ua + ub + uc;
            sr = sa + sb + uc;
            co = (ur >= 64'sd4294967296);
        end else begin
            ur = ua - ub - uc;
            sr = sa - sb - uc;
            co = (ua >= ub + uc);
        end
        s  = ur[31:0];
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {co, ov, (s == 32'd0), s};
    endfunction

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Applies one table record to all three builds and checks latency and result.
    task automatic apply_stimulus(input vec_t v);
        int          lat[3];
        logic [34:0] got[3];
        logic [34:0] exp;
        lat = '{-1, -1, -1};
        got = '{default: '0};
        exp = {v.exp_cout, v.exp_ovf, v.exp_zero, v.exp_sum};
        @(posedge clk); #1;
        a_in = v.a; b_in = v.b; cin_in = v.cin; sub_in = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check_output("vec_in_ready", {in_ready_s1, in_ready, in_ready_s4}, 3'b111);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (lat[0] < 0 && out_valid_s1) begin lat[0] = c; got[0] = {cout_s1, ovf_s1, zero_s1, sum_s1}; end
            if (lat[1] < 0 && out_valid)    begin lat[1] = c; got[1] = {cout, ovf, zero, sum}; end
            if (lat[2] < 0 && out_valid_s4) begin lat[2] = c; got[2] = {cout_s4, ovf_s4, zero_s4, sum_s4}; end
            @(posedge clk); #1;
        end
        check_output("latency_s1", 64'(lat[0]), 64'd0);
        check_output("latency_s2", 64'(lat[1]), 64'd1);
        check_output("latency_s4", 64'(lat[2]), 64'd3);
        check_output("result_s1", got[0], exp);
        check_output("result_s2", got[1], exp);
        check_output("result_s4", got[2], exp);
    endtask

    // Free-running source that holds each random beat until it is accepted.
    task automatic run_cycles(input int n, input bit src_on, input bit rdy);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (!in_valid || accepted_last) begin
                a_in   = $urandom;
                b_in   = $urandom;
                cin_in = 1'($urandom_range(0, 1));
                sub_in = 1'($urandom_range(0, 1));
            end
            in_valid  = src_on;
            out_ready = rdy;
            #1 accepted_last = in_valid && in_ready;
            if (rdy) check_output("throughput_in_ready", in_ready, 1'b1);
        end
    endtask

    // Scoreboard for the 2-stage build: order, values and hold-under-backpressure.
    initial begin
        logic [34:0] held;
        logic [34:0] exp_beat;
        bit          stall_prev;
        held = '0;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_output("hold_valid", out_valid, 1'b1);
                    check_output("hold_data", {cout, ovf, zero, sum}, held);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vectors++;
                        n_miscompares++;
                        $display("[TB] FAIL unexpected_beat: got 0x%0h, required no beat at %0t",
                                 {cout, ovf, zero, sum}, $time);
                    end else begin
                        exp_beat = exp_q.pop_front();
                        check_output("stream", {cout, ovf, zero, sum}, exp_beat);
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(ref_model(a_in, b_in, cin_in, sub_in));
                stall_prev = out_valid && !out_ready;
                held = {cout, ovf, zero, sum};
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000C, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_out_valid", {out_valid_s1, out_valid, out_valid_s4}, 3'b000);
        check_output("reset_result_s2", {cout, ovf, zero, sum}, 35'd0);
        check_output("reset_result_s4", {cout_s4, ovf_s4, zero_s4, sum_s4}, 35'd0);
        rst_n = 1'b1;
        #1 check_output("reset_in_ready", {in_ready_s1, in_ready, in_ready_s4}, 3'b111);

        for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

        run_cycles(8, 1'b1, 1'b1);
        run_cycles(6, 1'b0, 1'b1);
        check_output("stream_drained", 64'(exp_q.size()), 64'd0);

        run_cycles(3, 1'b1, 1'b1);
        run_cycles(5, 1'b1, 1'b0);
        check_output("backpressure_in_ready", in_ready, 1'b0);
        check_output("backpressure_out_valid", out_valid, 1'b1);
        run_cycles(4, 1'b1, 1'b1);
        run_cycles(6, 1'b0, 1'b1);
        check_output("backpressure_drained", 64'(exp_q.size()), 64'd0);

        run_cycles(2, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        accepted_last = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 check_output("midreset_in_ready", in_ready, 1'b1);
        for (int c = 0; c < 6; c++) begin
            check_output("midreset_out_valid", out_valid, 1'b0);
            @(posedge clk); #1;
        end
        run_cycles(4, 1'b1, 1'b1);
        run_cycles(6, 1'b0, 1'b1);
        check_output("final_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
